// File: rtl/rr_grant_fsm_if.sv
// Request/grant bundle between requesting engines and the round-robin arbiter.
// Handshake: req is a level request; a requester owns the resource in every cycle its grant bit is high.
interface rr_grant_fsm_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           err;
  logic [IDW-1:0] err_id;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  err,
    input  err_id
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output err,
    output err_id
  );
endinterface

// File: rtl/rr_grant_fsm.sv
// Round-robin Mealy arbiter for one shared single-owner resource.
// A hold watchdog ejects an owner that overstays and then enforces an error cooldown.
module rr_grant_fsm #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16,
  parameter int COOLDOWN = 4,
  parameter int CW       = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_grant_fsm_if.slave  bus,
  output logic [1:0]     o_state,
  output logic [IDW-1:0] o_ptr,
  output logic [IDW-1:0] o_owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam bit            WD_EN     = (MAX_HOLD != 0);
  localparam logic [CW-1:0] MAX_HOLD_C = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CD_LAST_C  = CW'(COOLDOWN - 1);
  localparam logic [CW-1:0] HOLD_ONE_C = CW'(1);

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_owner;
  logic [CW-1:0]  r_hold_cnt;
  logic [CW-1:0]  r_cd_cnt;
  logic [IDW-1:0] r_err_id;

  state_t         w_state_nxt;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW-1:0] w_owner_nxt;
  logic [CW-1:0]  w_hold_nxt;
  logic [CW-1:0]  w_cd_nxt;
  logic [IDW-1:0] w_err_id_nxt;
  logic [N-1:0]   w_grant;
  logic [N-1:0]   w_grant_q;
  logic           w_err;
  logic           w_win_found;
  logic [IDW-1:0] w_win_idx;
  logic [IDW-1:0] w_owner_inc;
  logic [IDW-1:0] w_grant_id;

  // Index base+k wrapped into 0..N-1.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
    int sum;
    sum = k;
    sum = sum + int'(base);
    return IDW'(sum % N);
  endfunction

  // Winner search starts at the pointer so the most recently served index goes last.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_win_found && bus.req[wrap_add(r_ptr, k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = wrap_add(r_ptr, k);
      end
    end
  end

  assign w_owner_inc = (r_owner == IDW'(N - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_hold_nxt   = r_hold_cnt;
    w_cd_nxt     = r_cd_cnt;
    w_err_id_nxt = r_err_id;
    w_grant      = '0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_grant[w_win_idx] = 1'b1;
          w_owner_nxt        = w_win_idx;
          w_hold_nxt         = HOLD_ONE_C;
          w_state_nxt        = S_OWN;
        end
      end
      S_OWN: begin
        if (!bus.req[r_owner]) begin
          // Release cycle is deliberately dead; the next winner is picked from S_IDLE.
          w_ptr_nxt   = w_owner_inc;
          w_state_nxt = S_IDLE;
        end else if (WD_EN && (r_hold_cnt == MAX_HOLD_C)) begin
          w_err_id_nxt = r_owner;
          w_ptr_nxt    = w_owner_inc;
          w_cd_nxt     = '0;
          w_state_nxt  = S_ERR;
        end else begin
          w_grant[r_owner] = 1'b1;
          w_hold_nxt       = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end
      end
      S_ERR: begin
        w_err    = 1'b1;
        w_cd_nxt = r_cd_cnt + 1'b1;
        if (r_cd_cnt == CD_LAST_C) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_cd_cnt   <= '0;
      r_err_id   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_cd_cnt   <= w_cd_nxt;
      r_err_id   <= w_err_id_nxt;
    end
  end

  // Reset masks the grant in the same cycle so an aborted tenure never leaks through.
  assign w_grant_q = rst ? '0 : w_grant;

  always_comb begin
    w_grant_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_q[i]) begin
        w_grant_id = IDW'(i);
      end
    end
  end

  assign bus.grant    = w_grant_q;
  assign bus.grant_id = w_grant_id;
  assign bus.busy     = |w_grant_q;
  assign bus.err      = w_err;
  assign bus.err_id   = r_err_id;

  assign o_state = r_state;
  assign o_ptr   = r_ptr;
  assign o_owner = r_owner;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed bench for rr_grant_fsm with default parameters and hand-computed expectations.
module tb_rr_grant_fsm;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_grant_fsm_if #(.N(N), .IDW(IDW)) bus ();
  logic [1:0]     dbg_state;
  logic [IDW-1:0] dbg_ptr;
  logic [IDW-1:0] dbg_owner;

  rr_grant_fsm #(
    .N(N), .IDW(IDW), .MAX_HOLD(16), .COOLDOWN(4), .CW(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state),
    .o_ptr   (dbg_ptr),
    .o_owner (dbg_owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] g, input logic [IDW-1:0] id,
                         input logic e);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(|g));
    chk({tag, ".err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v);
    bus.req = v;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    int o;
    bus.req = '0;
    rst = 1'b1;
    tick();
    tick();
    // reset holds outputs low even with every request up
    drive(4'b1111);
    chk_out("rst_force", 4'b0000, 2'd0, 1'b0);
    chk("rst.err_id", 32'(bus.err_id), 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    chk("rst.ptr", 32'(dbg_ptr), 32'd0);
    rst = 1'b0;
    drive(4'b0000);
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("idle%0d", i), 4'b0000, 2'd0, 1'b0);
      tick();
    end

    // same-cycle grant, release dead cycle, pointer moves past owner 0
    drive(4'b0101);
    chk_out("t2.c0", 4'b0001, 2'd0, 1'b0);
    tick();
    chk_out("t2.c1", 4'b0001, 2'd0, 1'b0);
    tick();
    chk_out("t2.c2", 4'b0001, 2'd0, 1'b0);
    tick();
    drive(4'b0100);
    chk_out("t2.drop", 4'b0000, 2'd0, 1'b0);
    chk("t2.drop.state", 32'(dbg_state), 32'd1);
    tick();
    chk_out("t2.next", 4'b0100, 2'd2, 1'b0);
    chk("t2.next.ptr", 32'(dbg_ptr), 32'd1);
    tick();
    drive(4'b0000);
    chk_out("t2.rel", 4'b0000, 2'd0, 1'b0);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // full contention: 0,1,2,3,0 with one dead cycle between tenures
    for (int k = 0; k < 5; k++) begin
      o = k % N;
      g = '0;
      g[o] = 1'b1;
      drive(4'b1111);
      chk_out($sformatf("rr%0d.a", k), g, IDW'(o), 1'b0);
      tick();
      chk_out($sformatf("rr%0d.b", k), g, IDW'(o), 1'b0);
      tick();
      drive(4'b1111 & ~g);
      chk_out($sformatf("rr%0d.dead", k), 4'b0000, 2'd0, 1'b0);
      tick();
    end

    // watchdog: 16 granted cycles, eject cycle, 4 cooldown cycles, re-grant
    drive(4'b0010);
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("wd.hold%0d", i), 4'b0010, 2'd1, 1'b0);
      tick();
    end
    chk_out("wd.eject", 4'b0000, 2'd0, 1'b0);
    chk("wd.eject.err_id", 32'(bus.err_id), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("wd.cd%0d", i), 4'b0000, 2'd0, 1'b1);
      chk($sformatf("wd.cd%0d.err_id", i), 32'(bus.err_id), 32'd1);
      chk($sformatf("wd.cd%0d.state", i), 32'(dbg_state), 32'd2);
      tick();
    end
    chk_out("wd.regrant", 4'b0010, 2'd1, 1'b0);
    chk("wd.regrant.ptr", 32'(dbg_ptr), 32'd2);
    tick();
    drive(4'b0000);
    chk_out("wd.rel", 4'b0000, 2'd0, 1'b0);
    tick();

    // reset mid tenure (owner 2, hold_cnt 5)
    drive(4'b0100);
    chk_out("rm.c0", 4'b0100, 2'd2, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("rm.own%0d", i), 4'b0100, 2'd2, 1'b0);
      tick();
    end
    rst = 1'b1;
    #1;
    chk_out("rm.rst", 4'b0000, 2'd0, 1'b0);
    tick();
    rst = 1'b0;
    drive(4'b1111);
    chk_out("rm.after", 4'b0001, 2'd0, 1'b0);
    tick();

    // owner 3 releases with 0 and 2 pending: pointer wraps to 0
    drive(4'b1110);
    chk_out("wrap.rel0", 4'b0000, 2'd0, 1'b0);
    tick();
    drive(4'b1000);
    chk_out("wrap.own3", 4'b1000, 2'd3, 1'b0);
    tick();
    drive(4'b0101);
    chk_out("wrap.dead", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("wrap.ptr", 32'(dbg_ptr), 32'd0);
    chk_out("wrap.next", 4'b0001, 2'd0, 1'b0);
    tick();
    drive(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_grant_fsm.md
Name: rr_grant_fsm

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters, built as a Mealy FSM.
- A grant is issued in the same cycle a request is seen while idle. It is held while the owner keeps its request asserted.
- A hold watchdog removes an owner that keeps the resource too long, then enforces an error cooldown.
- Sits between requesting engines and a shared single-owner resource (bus port, config interface, run/abort sequencer).

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, width of grant_id/err_id; must satisfy 2^IDW >= N.
- MAX_HOLD, 16, max granted cycles per tenure; 0 disables the watchdog.
- COOLDOWN, 4, cycles spent in S_ERR (>=1).
- CW, 8, width of the hold and cooldown counters; must hold MAX_HOLD and COOLDOWN.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request per requester, level-sensitive.
- grant  output  N  one-hot or zero; Mealy, combinational from state and req.
- grant_id  output  IDW  index of the asserted grant bit; 0 when grant==0.
- busy  output  1  |grant.
- err  output  1  high for every cycle in S_ERR.
- err_id  output  IDW  index of the last requester removed by the watchdog; registered.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On the reset edge: state=S_IDLE, ptr=0, owner=0, hold_cnt=0, cd_cnt=0, err_id=0.
  - grant, busy, grant_id are forced to 0 combinationally while rst=1.
  - rst asserted mid-tenure drops grant in that same cycle.
- Winner: first index i with req[i]=1, scanning ptr, ptr+1, … mod N.
- S_IDLE:
  - If req!=0: grant[winner]=1 in the same cycle. Next: S_OWN, owner<=winner, hold_cnt<=1.
  - Else: grant=0, stay.
- S_OWN, grant[owner]=req[owner] && (MAX_HOLD==0 || hold_cnt<MAX_HOLD):
  - If req[owner]=0 (release): grant=0 this cycle, ptr<=(owner+1) mod N, next S_IDLE.
    - The release cycle is always a dead cycle: no same-cycle handoff.
  - Else if watchdog is enabled and hold_cnt==MAX_HOLD: grant=0, err_id<=owner, ptr<=(owner+1) mod N, cd_cnt<=0, next S_ERR.
  - Else: grant held, hold_cnt<=hold_cnt+1.
  - Net effect: the owner receives exactly MAX_HOLD granted cycles, counting the S_IDLE grant cycle.
  - Requests from other requesters are ignored during S_OWN.
- S_ERR:
  - grant=0, err=1.
  - cd_cnt increments each cycle; when cd_cnt==COOLDOWN-1, next S_IDLE.
  - err is therefore high for exactly COOLDOWN cycles.
- Illegal state encoding: grant=0, err=0, next S_IDLE.
- ptr wraps from N-1 to 0. A sole requester is re-granted even if it was just released or ejected.
- grant_id: binary encode of grant; busy=|grant.
- Neither grant_id nor busy is ever X when req is known.

Test Plan:
- Reset, then req=0000 for 5 cycles -> grant=0000, busy=0, err=0, grant_id=0 every cycle.
- From reset, req=0101 -> grant=0001 in the same cycle.
  - Hold req[0] 3 cycles, then drop it -> grant=0000 in the drop cycle.
  - Next cycle grant=0100, grant_id=2.
- req=1111, each owner drops its req for one cycle after 2 granted cycles -> grant sequence 0001,0010,0100,1000,0001 with one dead cycle between tenures.
- Default params, req=0010 held constant -> grant=0010 for exactly 16 cycles, then grant=0000 with err=1 for 4 cycles, err_id=1. Then grant=0010 again, with ptr=2 but only req1 pending.
- rst pulsed while owner=2 with hold_cnt=5 -> grant=0000 in the rst cycle.
  - After rst, with req=1111, grant=0001 (ptr=0).
- Owner 3 releases while req0 and req2 are pending -> dead cycle, then grant=0001 (ptr wrapped to 0).
